mem_burst_initiator: RTL and testbench

- Initiator for the single-port simulation/SRAM memory interface: `req`/`write`/`addr`/`wdata`/`wmask`, with `rdata` valid exactly one cycle after a read request.
- Accepts burst commands on a valid/ready port and breaks each into per-word memory requests.
- Write data comes from a valid/ready input stream; read data returns on a valid/ready output stream with backpressure.
- Sits between test/DMA logic and the memory model.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_resp_fifo.sv | 57 +++++
 rtl/mem_burst_initiator.sv | 168 ++++++++++++++++
 tb/tb_mem_burst_initiator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================
// mem_pkg: shared types for the burst initiator and its FIFO
// Revision: 1.0
// ============================================================
`default_nettype none

package mem_pkg;

  // Response entries are sized by DATA_W. The top's Width must match it.
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_fifo.sv
// ============================================================
// mem_resp_fifo: 2-entry read-response FIFO, push+pop any cycle
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_resp_fifo
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  resp_t      push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output resp_t      head_o,
  output logic [1:0] count_o
);

  resp_t      r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign valid_o = (r_count != 2'd0);
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;
  assign w_pop   = pop_i & valid_o;

  // Push into a full FIFO only happens alongside a pop; the overwritten slot is the departing head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wptr] <= push_data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({push_i, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_burst_initiator.sv
// ============================================================
// mem_burst_initiator: burst commands to per-word SRAM requests
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter  int unsigned Width = DATA_W,
  parameter  int unsigned Depth = 1 << 15,
  parameter  int unsigned LenW  = 16,
  localparam int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [Aw-1:0]    cmd_addr_i,
  input  logic [LenW-1:0]  cmd_len_i,
  input  logic [Width-1:0] cmd_wmask_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [Aw-1:0]    mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  output logic [Width-1:0] mem_wmask_o,
  input  logic [Width-1:0] mem_rdata_i
);

  state_e           r_state;
  state_e           w_state_next;
  logic [Aw-1:0]    r_addr;
  logic [LenW-1:0]  r_remaining;
  logic [Width-1:0] r_wmask;
  logic             r_inflight;
  logic             r_inflight_last;

  logic             w_accept;
  logic             w_issue_rd;
  logic             w_issue_wr;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic [1:0]       w_after_pop;
  logic [Aw-1:0]    w_addr_inc;
  op_e              w_cmd_op;

  resp_t            w_push_data;
  resp_t            w_head;
  logic [1:0]       w_count;

  mem_resp_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_inflight),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .valid_o     (rd_valid_o),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign w_push_data.data = mem_rdata_i;
  assign w_push_data.last = r_inflight_last;
  assign rd_data_o        = w_head.data;
  assign rd_last_o        = rd_valid_o & w_head.last;
  assign w_pop            = rd_valid_o & rd_ready_i;

  // Buffered plus in-flight words after this cycle's pop; at most two may be outstanding.
  assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_after_pop = w_count - {1'b0, w_pop};
  assign w_addr_inc  = (r_addr == Aw'(Depth - 1)) ? '0 : r_addr + Aw'(1);
  assign w_cmd_op    = cmd_write_i ? OP_WRITE : OP_READ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready_o  = 1'b0;
    wr_ready_o   = 1'b0;
    busy_o       = (r_state != IDLE);
    done_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = r_addr;
    mem_wdata_o  = '0;
    mem_wmask_o  = '0;
    w_accept     = 1'b0;
    w_issue_rd   = 1'b0;
    w_issue_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          if (cmd_len_i == '0)            w_state_next = DONE;
          else if (w_cmd_op == OP_WRITE)  w_state_next = WRITE;
          else                            w_state_next = READ;
        end
      end
      WRITE: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          w_issue_wr  = 1'b1;
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          mem_wdata_o = wr_data_i;
          mem_wmask_o = r_wmask;
          if (r_remaining == LenW'(1)) w_state_next = DONE;
        end
      end
      READ: begin
        if ((r_remaining != '0) && (w_occ < 3'd2)) begin
          w_issue_rd = 1'b1;
          mem_req_o  = 1'b1;
          if (r_remaining == LenW'(1)) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_inflight && (w_after_pop == 2'd0)) w_state_next = DONE;
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_wmask         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue_rd;
      r_inflight_last <= w_issue_rd && (r_remaining == LenW'(1));
      if (w_accept) begin
        r_addr      <= cmd_addr_i;
        r_remaining <= cmd_len_i;
        r_wmask     <= cmd_wmask_i;
      end else if (w_issue_rd || w_issue_wr) begin
        r_addr      <= w_addr_inc;
        r_remaining <= r_remaining - LenW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_initiator.sv
// ============================================================
// tb_mem_burst_initiator: directed self-checking bench
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_mem_burst_initiator;

  localparam int DEPTH = 1 << 15;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [14:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [31:0] cmd_wmask_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_data_i = '0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b1;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        busy_o;
  logic        done_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [14:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_wmask_o;
  logic [31:0] mem_rdata_i = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_model [DEPTH];

  mem_burst_initiator dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_wmask_i (cmd_wmask_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .rd_last_o   (rd_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: bit-masked writes, read data registered one cycle after the request.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_write_o)
        mem_model[mem_addr_o] <= (mem_model[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
      else
        mem_rdata_i <= mem_model[mem_addr_o];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len, input logic [31:0] mask);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = 15'(addr);
    cmd_len_i   = 16'(len);
    cmd_wmask_i = mask;
    @(negedge clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_accept: cmd_ready=%b mem_req=%b, required 1 0", cmd_ready_o, mem_req_o);
    end
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle: done=%b busy=%b cmd_ready=%b, required 0 0 1", tag, done_o, busy_o, cmd_ready_o);
    end
    tick();
  endtask

  task automatic write_burst(input int addr, input int len, input logic [31:0] mask, input logic [31:0] base);
    int exp_a;
    send_cmd(1'b1, addr, len, mask);
    for (int i = 0; i < len; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = base + 32'(i);
      exp_a      = (addr + i) % DEPTH;
      @(negedge clk_i);
      vectors++;
      if (mem_req_o !== 1'b1 || mem_write_o !== 1'b1 || wr_ready_o !== 1'b1 ||
          mem_addr_o !== 15'(exp_a) || mem_wdata_o !== base + 32'(i) || mem_wmask_o !== mask) begin
        miscompares++;
        $display("FAIL write_beat%0d: req=%b we=%b rdy=%b addr=%h wdata=%h wmask=%h, required 1 1 1 %h %h %h",
                 i, mem_req_o, mem_write_o, wr_ready_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
                 15'(exp_a), base + 32'(i), mask);
      end
      tick();
    end
    wr_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b1 || mem_req_o !== 1'b0 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL write_done: done=%b req=%b busy=%b cmd_ready=%b, required 1 0 1 0",
               done_o, mem_req_o, busy_o, cmd_ready_o);
    end
    tick();
    check_idle("write");
  endtask

  // rd_ready held high: reads issue on cycles 1..len, data on 3..len+2, done on len+3.
  task automatic read_stream(input int addr, input int len, input logic [31:0] first);
    logic       e_valid, e_last, e_done, e_req;
    logic [31:0] e_data;
    rd_ready_i = 1'b1;
    send_cmd(1'b0, addr, len, 32'h0);
    for (int n = 1; n <= len + 3; n++) begin
      e_valid = (n >= 3) && (n <= len + 2);
      e_last  = (n == len + 2);
      e_done  = (n == len + 3);
      e_req   = (n <= len);
      e_data  = first + 32'(n - 3);
      @(negedge clk_i);
      vectors++;
      if (rd_valid_o !== e_valid || done_o !== e_done || mem_req_o !== e_req ||
          (e_valid && (rd_data_o !== e_data || rd_last_o !== e_last)) ||
          (e_req && (mem_write_o !== 1'b0 || mem_addr_o !== 15'((addr + n - 1) % DEPTH)))) begin
        miscompares++;
        $display("FAIL read_cycle%0d: valid=%b data=%h last=%b done=%b req=%b we=%b addr=%h, required %b %h %b %b %b 0 %h",
                 n, rd_valid_o, rd_data_o, rd_last_o, done_o, mem_req_o, mem_write_o, mem_addr_o,
                 e_valid, e_data, e_last, e_done, e_req, 15'((addr + n - 1) % DEPTH));
      end
      tick();
    end
    check_idle("read");
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1 || wr_ready_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_last_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: cmd_ready=%b wr_ready=%b rd_valid=%b rd_last=%b busy=%b done=%b req=%b, required 1 0 0 0 0 0 0",
               cmd_ready_o, wr_ready_o, rd_valid_o, rd_last_o, busy_o, done_o, mem_req_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_write_burst();
    write_burst(32'h10, 4, 32'hFFFF_FFFF, 32'hA0);
  endtask

  task automatic test_read_back();
    read_stream(32'h10, 4, 32'hA0);
  endtask

  task automatic test_backpressure();
    int  issued, popped;
    bit  got_done;
    write_burst(32'h40, 6, 32'hFFFF_FFFF, 32'h100);
    issued   = 0;
    popped   = 0;
    got_done = 0;
    send_cmd(1'b0, 32'h40, 6, 32'h0);
    for (int cyc = 0; cyc < 80 && !got_done; cyc++) begin
      rd_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clk_i);
      vectors++;
      if (issued - popped > 2) begin
        miscompares++;
        $display("FAIL bp_outstanding: %0d outstanding, required at most 2", issued - popped);
      end
      if (mem_req_o) begin
        vectors++;
        if (mem_write_o !== 1'b0 || mem_addr_o !== 15'(32'h40 + issued) || issued >= 6) begin
          miscompares++;
          $display("FAIL bp_issue%0d: we=%b addr=%h, required 0 %h", issued, mem_write_o, mem_addr_o,
                   15'(32'h40 + issued));
        end
        issued++;
      end
      if (rd_valid_o && rd_ready_i) begin
        vectors++;
        if (rd_data_o !== 32'h100 + 32'(popped) || rd_last_o !== (popped == 5)) begin
          miscompares++;
          $display("FAIL bp_data%0d: data=%h last=%b, required %h %b", popped, rd_data_o, rd_last_o,
                   32'h100 + 32'(popped), (popped == 5));
        end
        popped++;
      end
      if (done_o) got_done = 1;
      tick();
    end
    rd_ready_i = 1'b1;
    vectors++;
    if (!got_done || popped != 6 || issued != 6) begin
      miscompares++;
      $display("FAIL bp_totals: done_seen=%0d popped=%0d issued=%0d, required 1 6 6", got_done, popped, issued);
    end
    check_idle("bp");
  endtask

  task automatic test_wrap_mask();
    write_burst(DEPTH - 2, 4, 32'h0000_FFFF, 32'hBEEF_0000);
  endtask

  task automatic test_zero_len();
    for (int op = 0; op < 2; op++) begin
      send_cmd(op[0], 32'h20, 0, 32'hFFFF_FFFF);
      @(negedge clk_i);
      vectors++;
      if (done_o !== 1'b1 || mem_req_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_len_op%0d: done=%b req=%b cmd_ready=%b, required 1 0 0", op, done_o, mem_req_o, cmd_ready_o);
      end
      tick();
      check_idle("zero_len");
    end
  endtask

  task automatic test_reset_mid_burst();
    rd_ready_i = 1'b1;
    send_cmd(1'b0, 32'h10, 4, 32'h0);
    tick();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (cmd_ready_o !== 1'b1 || wr_ready_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_last_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: cmd_ready=%b wr_ready=%b rd_valid=%b rd_last=%b busy=%b done=%b req=%b, required 1 0 0 0 0 0 0",
               cmd_ready_o, wr_ready_o, rd_valid_o, rd_last_o, busy_o, done_o, mem_req_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      vectors++;
      if (rd_valid_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_after%0d: rd_valid=%b done=%b req=%b, required 0 0 0", n, rd_valid_o, done_o, mem_req_o);
      end
      tick();
    end
    read_stream(32'h11, 2, 32'hA1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    test_reset();
    test_write_burst();
    test_read_back();
    test_backpressure();
    test_wrap_mask();
    test_zero_len();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
